// File: rtl/key_pkg.sv
// Shared definitions for the key press emulator and its loopback click detector:
// FSM encoding, counter widths, call/trigger bit positions and default timings.
package key_pkg;

  localparam int CNT_W  = 28;
  localparam int BCNT_W = 4;

  // Bit positions inside iCall / oTrig vectors
  localparam int CALL_SHORT = 1;
  localparam int CALL_LONG  = 0;

  localparam int T10MS_DEF = 500_000;
  // Exceeds the detector's long-press time plus one debounce window
  localparam int TLONG_DEF = 200_000_000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRESS_BNC,
    ST_HOLD,
    ST_RELEASE_BNC,
    ST_GAP,
    ST_DONE
  } state_e;

endpackage

// File: rtl/key_bounce_seq.sv
// Bounce edge sequencer: while active, strobes a toggle each time the shared cycle
// counter reaches TBOUNCE-1 and flags the last of the 2*NBOUNCE toggles.
module key_bounce_seq
  import key_pkg::*;
#(
  parameter int TBOUNCE = 20_000,
  parameter int NBOUNCE = 3
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             iActive,
  input  logic [CNT_W-1:0] iCnt,
  output logic             oToggle,
  output logic             oDone
);

  logic [BCNT_W-1:0] edge_q, edge_d;

  always_comb begin
    oToggle = iActive && (iCnt == CNT_W'(TBOUNCE - 1));
    oDone   = oToggle && (edge_q == BCNT_W'(2 * NBOUNCE - 1));
    edge_d  = edge_q;
    if (!iActive || oDone) begin
      edge_d = '0;
    end else if (oToggle) begin
      edge_d = edge_q + BCNT_W'(1);
    end
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      edge_q <= '0;
    end else begin
      edge_q <= edge_d;
    end
  end

endmodule

// File: rtl/key_press_gen.sv
// Key press emulator: drives an active-low KEY line through a bounced press,
// a short or long hold, a bounced release and an idle gap, then pulses oDone.
module key_press_gen
  import key_pkg::*;
#(
  parameter int T10MS   = T10MS_DEF,
  parameter int TBOUNCE = 20_000,
  parameter int NBOUNCE = 3,
  parameter int TSHORT  = 25_000_000,
  parameter int TLONG   = TLONG_DEF,
  parameter int TGAP    = 1_000_000
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic [1:0] iCall,
  output logic       KEY,
  output logic       oBusy,
  output logic       oDone
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] c1_q, c1_d;
  logic             long_q, long_d;
  logic             key_q, key_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             bnc_active, bnc_tog, bnc_done;
  logic [CNT_W-1:0] thold_m1;

  assign bnc_active = (state_q == ST_PRESS_BNC) || (state_q == ST_RELEASE_BNC);
  assign thold_m1   = long_q ? CNT_W'(TLONG - 1) : CNT_W'(TSHORT - 1);

  key_bounce_seq #(
    .TBOUNCE (TBOUNCE),
    .NBOUNCE (NBOUNCE)
  ) u_bnc (
    .CLOCK   (CLOCK),
    .RESET   (RESET),
    .iActive (bnc_active),
    .iCnt    (c1_q),
    .oToggle (bnc_tog),
    .oDone   (bnc_done)
  );

  // C1 restarts at every KEY edge so each interval is measured from the last edge
  always_comb begin
    state_d = state_q;
    c1_d    = c1_q + CNT_W'(1);
    long_d  = long_q;
    key_d   = key_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        c1_d = '0;
        if (iCall[CALL_SHORT] || iCall[CALL_LONG]) begin
          long_d  = !iCall[CALL_SHORT];
          key_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = (NBOUNCE == 0) ? ST_HOLD : ST_PRESS_BNC;
        end
      end
      ST_PRESS_BNC: begin
        if (bnc_tog) begin
          key_d = !key_q;
          c1_d  = '0;
          if (bnc_done) state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (c1_q == thold_m1) begin
          key_d   = 1'b1;
          c1_d    = '0;
          state_d = (NBOUNCE == 0) ? ST_GAP : ST_RELEASE_BNC;
        end
      end
      ST_RELEASE_BNC: begin
        if (bnc_tog) begin
          key_d = !key_q;
          c1_d  = '0;
          if (bnc_done) state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (c1_q == CNT_W'(TGAP - 1)) begin
          c1_d    = '0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        c1_d    = '0;
        state_d = ST_IDLE;
      end
      default: begin
        c1_d    = '0;
        key_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state_q <= ST_IDLE;
      c1_q    <= '0;
      long_q  <= 1'b0;
      key_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      c1_q    <= c1_d;
      long_q  <= long_d;
      key_q   <= key_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign KEY   = key_q;
  assign oBusy = busy_q;
  assign oDone = done_q;

  // Bounce bursts must settle inside the receiver window, and the gap must cover it
  always @(posedge CLOCK) begin
    assert ((2 * NBOUNCE * TBOUNCE < T10MS) && (TGAP >= T10MS))
      else $error("key_press_gen: timing parameters violate the debounce window");
  end

endmodule
